sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 53 +++++
 rtl/sprite_rom_arbiter.sv | 79 +++++++
 tb/tb_sprite_rom_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared defaults and types for the sprite ROM arbiter.
// Sizing targets a 256x256 palette-indexed image in one BRAM.
package sprite_pkg;

  localparam int SPR_NUM_REQ      = 4;
  localparam int SPR_ADDR_WIDTH   = 16;
  localparam int SPR_DATA_WIDTH   = 8;
  localparam int SPR_READ_LATENCY = 2;

  typedef logic [SPR_NUM_REQ-1:0] req_oh_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search with a last-grant pointer.
// The grant is combinational; the pointer moves only on a grant.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = SPR_NUM_REQ
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  int            best;
  int            sel;
  int            off;

  // off is the distance from the slot just after the pointer
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    best    = NUM_REQ;
    sel     = 0;
    off     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - 1 - int'(ptr_q)) % NUM_REQ;
      if (en_i && valid_i[i] && off < best) begin
        best = off;
        sel  = i;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = (best < NUM_REQ) && (sel == i);
    end
    if (best < NUM_REQ) begin
      ptr_d = PW'(sel);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= PW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one pipelined image ROM read port among sprite requesters.
// A one-hot tag rides alongside each read to steer the response.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ      = SPR_NUM_REQ,
  parameter int ADDR_WIDTH   = SPR_ADDR_WIDTH,
  parameter int DATA_WIDTH   = SPR_DATA_WIDTH,
  parameter int READ_LATENCY = SPR_READ_LATENCY
) (
  input  logic                                pixel_clk_in,
  input  logic                                rst_in,
  input  logic                                pause_in,
  input  logic [NUM_REQ-1:0]                  req_valid_in,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_in,
  output logic [NUM_REQ-1:0]                  req_ready_out,
  output logic [NUM_REQ-1:0]                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0]               rsp_data_out,
  output logic                                rom_en_out,
  output logic [ADDR_WIDTH-1:0]               rom_addr_out,
  input  logic [DATA_WIDTH-1:0]               rom_data_in
);

  logic [NUM_REQ-1:0]    gnt;
  logic                  arb_en;
  logic                  accept;
  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [ADDR_WIDTH-1:0] rom_addr_d;
  logic [NUM_REQ-1:0]    rom_tag_q;
  logic [NUM_REQ-1:0]    tag_q [READ_LATENCY];

  // Reset low also blocks grants, so ready is never seen during reset
  assign arb_en = ~pause_in & rst_in;
  assign accept = |gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i   (pixel_clk_in),
    .rst_ni  (rst_in),
    .en_i    (arb_en),
    .valid_i (req_valid_in),
    .grant_o (gnt)
  );

  always_comb begin
    rom_addr_d = rom_addr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rom_addr_d = req_addr_in[i];
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_tag_q  <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rom_en_q   <= accept;
      rom_addr_q <= rom_addr_d;
      rom_tag_q  <= gnt;
      tag_q[0]   <= rom_tag_q;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign req_ready_out = gnt;
  assign rom_en_out    = rom_en_q;
  assign rom_addr_out  = rom_addr_q;
  assign rsp_valid_out = tag_q[READ_LATENCY-1];
  assign rsp_data_out  = rom_data_in;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized and directed bench for sprite_rom_arbiter.
// A queue-based reference model predicts grants and responses.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N  = SPR_NUM_REQ;
  localparam int AW = SPR_ADDR_WIDTH;
  localparam int DW = SPR_DATA_WIDTH;
  localparam int RL = SPR_READ_LATENCY;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  pause = 1'b0;
  logic [N-1:0]          vld = '0;
  logic [N-1:0][AW-1:0]  addr = '0;
  logic [N-1:0]          rdy;
  logic [N-1:0]          rsp_v;
  logic [DW-1:0]         rsp_d;
  logic                  rom_en;
  logic [AW-1:0]         rom_addr;
  logic [DW-1:0]         rom_data;

  always #5 clk = ~clk;

  sprite_rom_arbiter dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_n),
    .pause_in      (pause),
    .req_valid_in  (vld),
    .req_addr_in   (addr),
    .req_ready_out (rdy),
    .rsp_valid_out (rsp_v),
    .rsp_data_out  (rsp_d),
    .rom_en_out    (rom_en),
    .rom_addr_out  (rom_addr),
    .rom_data_in   (rom_data)
  );

  // ROM model: data = addr[7:0], RL cycles after the address
  logic [AW-1:0] rp [RL];
  always @(posedge clk) begin
    rp[0] <= rom_addr;
    for (int s = 1; s < RL; s++) rp[s] <= rp[s-1];
  end
  assign rom_data = DW'(rp[RL-1][7:0]);

  typedef struct {
    int            id;
    logic [AW-1:0] a;
    int            due;
  } rd_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last = N - 1;
  logic          exp_en = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  req_oh_t       acc = '0;
  rd_t           pend [$];

  function automatic req_oh_t model_grant();
    int i;
    if (!rst_n || pause) return '0;
    for (int k = 1; k <= N; k++) begin
      i = (last + k) % N;
      if (vld[i]) return req_oh_t'(1) << i;
    end
    return '0;
  endfunction

  function automatic req_oh_t exp_rv();
    if (pend.size() > 0 && pend[0].due == cyc)
      return req_oh_t'(1) << pend[0].id;
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_rd();
    if (pend.size() > 0) return DW'(pend[0].a[7:0]);
    return '0;
  endfunction

  task automatic model_reset();
    pend.delete();
    last     = N - 1;
    exp_en   = 1'b0;
    exp_addr = '0;
    acc      = '0;
  endtask

  task automatic commit();
    req_oh_t g;
    g = model_grant();
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    acc    = g;
    exp_en = (g != '0);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        last     = i;
        exp_addr = addr[i];
        pend.push_back('{i, addr[i], cyc + 1 + RL});
      end
    end
    if (!rst_n) model_reset();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    vld = '1;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (rdy !== '0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", rdy);
    end
    checks++;
    if (rom_en !== 1'b0) begin
      errors++; $display("FAIL reset_rom_en: got %b expected 0", rom_en);
    end
    checks++;
    if (rom_addr !== '0) begin
      errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
    end
    checks++;
    if (rsp_v !== '0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_v);
    end
    commit();
    next();
    rst_n = 1'b1;
  endtask

  task automatic test_drain(input int n);
    vld = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_v !== exp_rv()) begin
        errors++; $display("FAIL drain_rsp: got %b expected %b", rsp_v, exp_rv());
      end
      commit();
      next();
    end
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
    vld = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (rdy !== (req_oh_t'(1) << (k % N))) begin
        errors++; $display("FAIL all_grant k=%0d: got %b expected %b", k, rdy, req_oh_t'(1) << (k % N));
      end
      if (k >= 1 + RL) begin
        checks++;
        if (rsp_v !== (req_oh_t'(1) << ((k - 1 - RL) % N))) begin
          errors++; $display("FAIL all_rsp_order k=%0d: got %b", k, rsp_v);
        end
        checks++;
        if (rsp_d !== exp_rd()) begin
          errors++; $display("FAIL all_rsp_data: got %h expected %h", rsp_d, exp_rd());
        end
      end
      checks++;
      if (rom_en !== exp_en || rom_addr !== exp_addr) begin
        errors++; $display("FAIL all_rom: got %b/%h expected %b/%h", rom_en, rom_addr, exp_en, exp_addr);
      end
      commit();
      next();
      for (int i = 0; i < N; i++) if (acc[i]) addr[i] = AW'($urandom);
    end
  endtask

  task automatic test_single();
    vld = 4'b0100;
    addr[2] = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 4'b0100) begin
        errors++; $display("FAIL single_grant: got %b expected 0100", rdy);
      end
      if (k >= 1) begin
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 16'h1234) begin
          errors++; $display("FAIL single_rom: got %b/%h expected 1/1234", rom_en, rom_addr);
        end
      end
      if (k >= 1 + RL) begin
        checks++;
        if (rsp_v !== 4'b0100 || rsp_d !== 8'h34) begin
          errors++; $display("FAIL single_rsp: got %b/%h expected 0100/34", rsp_v, rsp_d);
        end
      end
      commit();
      next();
    end
  endtask

  task automatic test_wrap();
    vld = 4'b1000;
    addr[0] = 16'h0a0a;
    addr[3] = 16'h0b3b;
    @(negedge clk);
    checks++;
    if (rdy !== 4'b1000) begin
      errors++; $display("FAIL wrap_setup: got %b expected 1000", rdy);
    end
    commit();
    next();
    vld = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rdy !== ((k % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        errors++; $display("FAIL wrap_grant k=%0d: got %b", k, rdy);
      end
      checks++;
      if (rsp_v !== exp_rv()) begin
        errors++; $display("FAIL wrap_rsp: got %b expected %b", rsp_v, exp_rv());
      end
      commit();
      next();
    end
  endtask

  task automatic test_pause();
    int seen;
    seen = 0;
    for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
    vld = '1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      commit();
      next();
      for (int i = 0; i < N; i++) if (acc[i]) addr[i] = AW'($urandom);
    end
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rdy !== '0) begin
        errors++; $display("FAIL pause_grant: got %b expected 0", rdy);
      end
      checks++;
      if (rsp_v !== exp_rv() || (exp_rv() != '0 && rsp_d !== exp_rd())) begin
        errors++; $display("FAIL pause_rsp: got %b/%h expected %b/%h", rsp_v, rsp_d, exp_rv(), exp_rd());
      end
      if (rsp_v != '0) seen++;
      commit();
      next();
    end
    checks++;
    if (seen !== 2) begin
      errors++; $display("FAIL pause_inflight: got %0d expected 2", seen);
    end
    pause = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 4'b0100) begin
      errors++; $display("FAIL pause_ptr: got %b expected 0100", rdy);
    end
    commit();
    next();
  endtask

  task automatic test_reset_mid();
    vld = '1;
    @(negedge clk);
    commit();
    next();
    rst_n = 1'b0;
    vld = '0;
    model_reset();
    @(negedge clk);
    checks++;
    if (rdy !== '0 || rom_en !== 1'b0 || rsp_v !== '0) begin
      errors++; $display("FAIL rstmid_clear: got %b/%b/%b expected 0/0/0", rdy, rom_en, rsp_v);
    end
    commit();
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_v !== '0) begin
        errors++; $display("FAIL rstmid_ghost: got %b expected 0", rsp_v);
      end
      commit();
      next();
    end
    vld = '1;
    @(negedge clk);
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL rstmid_first: got %b expected 0001", rdy);
    end
    commit();
    next();
  endtask

  task automatic test_random();
    int      wt [N];
    req_oh_t g;
    for (int i = 0; i < N; i++) wt[i] = 0;
    vld = '0;
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) vld[i] = 1'b0;
        if (!vld[i] && ($urandom % 3) == 0) begin
          vld[i]  = 1'b1;
          addr[i] = AW'($urandom);
        end
      end
      @(negedge clk);
      g = model_grant();
      checks++;
      if (rdy !== g) begin
        errors++; $display("FAIL rand_grant: got %b expected %b", rdy, g);
      end
      checks++;
      if (rsp_v !== exp_rv() || (exp_rv() != '0 && rsp_d !== exp_rd())) begin
        errors++; $display("FAIL rand_rsp: got %b/%h expected %b/%h", rsp_v, rsp_d, exp_rv(), exp_rd());
      end
      checks++;
      if (rom_en !== exp_en || rom_addr !== exp_addr) begin
        errors++; $display("FAIL rand_rom: got %b/%h expected %b/%h", rom_en, rom_addr, exp_en, exp_addr);
      end
      for (int i = 0; i < N; i++) begin
        if (vld[i]) wt[i]++;
        if (rdy[i]) begin
          checks++;
          if (wt[i] > N) begin
            errors++; $display("FAIL rand_wait req=%0d: got %0d expected <=%0d", i, wt[i], N);
          end
          wt[i] = 0;
        end
      end
      commit();
      next();
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_drain(4);
    test_single();
    test_drain(4);
    test_wrap();
    test_drain(4);
    test_pause();
    test_drain(4);
    test_reset_mid();
    test_drain(4);
    test_random();
    test_drain(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
